// File: rtl/inst_fetch_unit_if.sv
// Bundle of the instruction-memory read bus, the redirect request and the
// decode-side valid/ready handshake between the fetch unit and its surroundings.
interface inst_fetch_unit_if;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus2;
  logic        out_ready;
  logic        halted;

  modport master (
    output imem_addr, imem_enable, imem_wr,
    input  imem_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_pc_plus2,
    input  out_ready,
    output halted
  );

  modport slave (
    input  imem_addr, imem_enable, imem_wr,
    output imem_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_pc_plus2,
    output out_ready,
    input  halted
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 16-bit words from instruction memory,
// queues {instr, pc} pairs for decode and handles redirects and halt words.
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          DEPTH       = 2,
  parameter int          START_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {WAIT, FETCH, HALT} state_t;

  state_t         state_reg, state_next;
  logic [15:0]    pc_reg, pc_next;
  logic [3:0]     delay_reg, delay_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [15:0]    instr_q [DEPTH];
  logic [15:0]    pc_q    [DEPTH];

  logic fetch;
  logic pop;
  logic halt_word;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    delay_next = delay_reg;
    fetch      = 1'b0;
    pop        = 1'b0;
    halt_word  = 1'b0;

    // Fullness is judged before any pop, so a full FIFO never fetches this cycle.
    fetch     = (state_reg == FETCH) && (count_reg < CW'(DEPTH)) && !bus.redirect_valid;
    pop       = (count_reg != '0) && bus.out_ready && !bus.redirect_valid;
    halt_word = fetch && (bus.imem_data[15:11] == 5'b00000);

    case (state_reg)
      WAIT: begin
        delay_next = delay_reg + 4'd1;
        if (delay_reg == 4'(START_DELAY - 1))
          state_next = FETCH;
      end
      FETCH: begin
        if (fetch) begin
          if (halt_word)
            state_next = HALT;
          else
            pc_next = pc_reg + 16'd2;
        end
      end
      default: ;
    endcase

    // A redirect during the start-up wait only retargets the PC.
    if (bus.redirect_valid) begin
      pc_next = {bus.redirect_pc[15:1], 1'b0};
      if (state_reg != WAIT)
        state_next = FETCH;
    end

    if (bus.redirect_valid)
      count_next = '0;
    else
      count_next = count_reg + CW'(fetch) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= WAIT;
      pc_reg     <= RESET_PC & 16'hFFFE;
      delay_reg  <= 4'd0;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      delay_reg <= delay_next;
      count_reg <= count_next;
      if (bus.redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (fetch) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Entries are cleared on reset so the head reads as zero before anything is fetched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 16'h0000;
        pc_q[i]    <= 16'h0000;
      end
    end else if (fetch) begin
      instr_q[wr_ptr_reg] <= bus.imem_data;
      pc_q[wr_ptr_reg]    <= pc_reg;
    end
  end

  assign bus.imem_addr    = pc_reg;
  assign bus.imem_enable  = fetch;
  assign bus.imem_wr      = 1'b0;
  assign bus.out_valid    = (count_reg != '0);
  assign bus.out_instr    = instr_q[rd_ptr_reg];
  assign bus.out_pc       = pc_q[rd_ptr_reg];
  assign bus.out_pc_plus2 = pc_q[rd_ptr_reg] + 16'd2;
  assign bus.halted       = (state_reg == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a queue-based model of the fetch stream
// predicts memory requests and the decode-side head every cycle.
module tb_inst_fetch_unit;

  localparam int DEPTH       = 2;
  localparam int START_DELAY = 1;
  localparam int NUM_CYCLES  = 600;

  localparam int M_WAIT  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;

  logic clk;
  logic rst;
  logic [15:0] mem [32768];

  inst_fetch_unit_if bus_if ();

  inst_fetch_unit #(
    .RESET_PC    (16'h0000),
    .DEPTH       (DEPTH),
    .START_DELAY (START_DELAY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  assign bus_if.imem_data = mem[bus_if.imem_addr[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_passed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp)
      checks_passed++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model state: program-order queue of {instr, pc} not yet accepted.
  logic [31:0] m_q [$];
  logic [15:0] m_pc;
  int          m_state;
  int          m_wait_cnt;

  task automatic model_reset();
    m_q.delete();
    m_pc       = 16'h0000;
    m_state    = M_WAIT;
    m_wait_cnt = 0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] head_pc;
    logic [15:0] head_pc2;
    logic [15:0] tgt;
    logic [15:0] fdata;
    bit          exp_fetch;
    bit          exp_pop;
    bit          redir;
    int          next_state;

    checks_total  = 0;
    checks_passed = 0;

    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000 && $urandom_range(0, 3) != 0)
        w[15:11] = 5'b10101;
      mem[i] = w;
    end
    mem[0]      = 16'h1111;
    mem[1]      = 16'h2222;
    mem[2]      = 16'h3333;
    mem[3]      = 16'h0000;
    mem[8]      = 16'h8888;
    mem[32]     = 16'h4040;
    mem[32767]  = 16'hABCD;

    rst                   = 1'b0;
    bus_if.out_ready      = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 16'h0000;
    model_reset();

    @(negedge clk);
    chk("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("reset_imem_enable", 32'(bus_if.imem_enable), 32'd0);
    chk("reset_halted", 32'(bus_if.halted), 32'd0);
    chk("reset_out_instr", 32'(bus_if.out_instr), 32'd0);
    chk("reset_out_pc", 32'(bus_if.out_pc), 32'd0);
    chk("reset_out_pc_plus2", 32'(bus_if.out_pc_plus2), 32'd2);
    chk("reset_imem_addr", 32'(bus_if.imem_addr), 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      // Short asynchronous reset pulse between clock edges.
      if (cyc == 200 || cyc == 450) begin
        rst = 1'b0;
        #1;
        chk("rstpulse_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rstpulse_halted", 32'(bus_if.halted), 32'd0);
        chk("rstpulse_imem_enable", 32'(bus_if.imem_enable), 32'd0);
        rst = 1'b1;
        #1;
        model_reset();
        $display("cycle %0d: reset pulse", cyc);
      end

      if ((cyc % 50) < 8)
        bus_if.out_ready = 1'b0;
      else
        bus_if.out_ready = ($urandom_range(0, 3) != 0);

      redir = (cyc > 12) && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 16'h0041;
        1:       tgt = 16'hFFFF;
        2:       tgt = 16'h0010;
        default: tgt = 16'($urandom_range(0, 255));
      endcase
      bus_if.redirect_valid = redir;
      bus_if.redirect_pc    = tgt;

      @(negedge clk);
      exp_fetch = (m_state == M_FETCH) && (m_q.size() < DEPTH) && !redir;
      exp_pop   = (m_q.size() != 0) && bus_if.out_ready && !redir;

      chk("imem_enable", 32'(bus_if.imem_enable), 32'(exp_fetch));
      chk("imem_wr", 32'(bus_if.imem_wr), 32'd0);
      if (exp_fetch)
        chk("imem_addr", 32'(bus_if.imem_addr), 32'(m_pc));
      chk("out_valid", 32'(bus_if.out_valid), 32'(m_q.size() != 0));
      chk("halted", 32'(bus_if.halted), 32'(m_state == M_HALT));
      if (m_q.size() != 0) begin
        head_pc  = m_q[0][15:0];
        head_pc2 = head_pc + 16'd2;
        chk("out_instr", 32'(bus_if.out_instr), 32'(m_q[0][31:16]));
        chk("out_pc", 32'(bus_if.out_pc), 32'(head_pc));
        chk("out_pc_plus2", 32'(bus_if.out_pc_plus2), 32'(head_pc2));
      end

      // Advance the model across the coming rising edge.
      next_state = m_state;
      if (m_state == M_WAIT) begin
        m_wait_cnt++;
        if (m_wait_cnt >= START_DELAY)
          next_state = M_FETCH;
      end

      if (redir) begin
        m_q.delete();
        m_pc = tgt & 16'hFFFE;
        if (m_state != M_WAIT)
          next_state = M_FETCH;
        $display("cycle %0d: redirect to 0x%04h", cyc, m_pc);
      end else begin
        if (exp_pop) begin
          $display("cycle %0d: deliver instr 0x%04h pc 0x%04h", cyc, m_q[0][31:16], m_q[0][15:0]);
          void'(m_q.pop_front());
        end
        if (exp_fetch) begin
          fdata = mem[m_pc[15:1]];
          m_q.push_back({fdata, m_pc});
          if (fdata[15:11] == 5'b00000)
            next_state = M_HALT;
          else
            m_pc = m_pc + 16'd2;
        end
      end
      m_state = next_state;

      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
